max_adc_responder: RTL and testbench

- Synthesizable responder (slave) end of the dual serial-ADC link driven by the acquisition front end.
- Emulates two MAX186-style ADCs that share one DIN/SCLK pair. Each ADC has its own DOUT/SSTRB pair.
- Decodes control bytes on DIN and answers with SSTRB plus a 16-bit serial frame per ADC.
- Used for board loopback and for closed-loop simulation of the acquisition path, with no real converters fitted.

---
 rtl/max_adc_responder.sv | 199 +++++++++++++++++++
 tb/tb_max_adc_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/max_adc_responder.sv
// Responder end of the dual MAX186-style serial ADC link: decodes control bytes on DIN and answers
// with SSTRB plus a 16-bit frame per lane. Define MAX_ADC_RESPONDER_RAMP_EN for internal ramp data.
module max_adc_responder #(
  parameter int unsigned DATA_BITS   = 12,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 ad_sclk,
  input  logic                 ad_din,
  output logic                 ad_dout0,
  output logic                 ad_sstrb0,
  output logic                 ad_dout1,
  output logic                 ad_sstrb1,
  output logic [2:0]           sample_chan,
  output logic                 sample_req,
  input  logic [DATA_BITS-1:0] sample_data0,
  input  logic [DATA_BITS-1:0] sample_data1,
  output logic                 cmd_err,
  output logic                 busy
);

  localparam int unsigned PadBits = 16 - DATA_BITS;

  typedef enum logic [1:0] {StIdle, StCmd, StStrb, StData} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, din_sync_q;
  logic                   sclk_prev_q, rise_q, fall_q;
  logic                   din_s, sclk_s;
  logic [5:0]             cmd_q, cmd_d;
  logic [4:0]             cnt_q, cnt_d;
  logic                   strb_seen_q, strb_seen_d;
  logic [15:0]            sh0_q, sh0_d, sh1_q, sh1_d;
  logic                   dout0_q, dout0_d, dout1_q, dout1_d, sstrb_q, sstrb_d;
  logic [2:0]             chan_q, chan_d;
  logic                   req_q, req_d, err_q, err_d, busy_q, busy_d;
  logic                   frame_done;
  logic [DATA_BITS-1:0]   cap0, cap1;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign din_s  = din_sync_q[SYNC_STAGES-1];

`ifdef MAX_ADC_RESPONDER_RAMP_EN
  logic [DATA_BITS-4:0] ramp_q [8];

  assign cap0 = {chan_q, ramp_q[chan_q]};
  assign cap1 = ~cap0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 8; i++) ramp_q[i] <= '0;
    end else if (frame_done) begin
      ramp_q[chan_q] <= ramp_q[chan_q] + 1'b1;
    end
  end
`else
  assign cap0 = sample_data0;
  assign cap1 = sample_data1;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sclk_sync_q <= '0;
      din_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      state_q     <= StIdle;
      cmd_q       <= '0;
      cnt_q       <= '0;
      strb_seen_q <= 1'b0;
      sh0_q       <= '0;
      sh1_q       <= '0;
      dout0_q     <= 1'b0;
      dout1_q     <= 1'b0;
      sstrb_q     <= 1'b0;
      chan_q      <= '0;
      req_q       <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], ad_sclk};
      din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], ad_din};
      sclk_prev_q <= sclk_s;
      rise_q      <= sclk_s & ~sclk_prev_q;
      fall_q      <= ~sclk_s & sclk_prev_q;
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cnt_q       <= cnt_d;
      strb_seen_q <= strb_seen_d;
      sh0_q       <= sh0_d;
      sh1_q       <= sh1_d;
      dout0_q     <= dout0_d;
      dout1_q     <= dout1_d;
      sstrb_q     <= sstrb_d;
      chan_q      <= chan_d;
      req_q       <= req_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cnt_d       = cnt_q;
    strb_seen_d = strb_seen_q;
    sh0_d       = sh0_q;
    sh1_d       = sh1_q;
    dout0_d     = dout0_q;
    dout1_d     = dout1_q;
    sstrb_d     = sstrb_q;
    chan_d      = chan_q;
    req_d       = 1'b0;
    err_d       = 1'b0;
    busy_d      = busy_q;
    frame_done  = 1'b0;

    // Capture the result the cycle after the request pulse; the frame is MSB-aligned.
    if (req_q) begin
      sh0_d = 16'(cap0) << PadBits;
      sh1_d = 16'(cap1) << PadBits;
    end

    unique case (state_q)
      StIdle: begin
        if (rise_q && din_s) begin
          state_d = StCmd;
          cmd_d   = '0;
          cnt_d   = 5'd1;
        end
      end
      StCmd: begin
        if (rise_q) begin
          cmd_d = {cmd_q[4:0], din_s};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd7) begin
            // cmd_q holds SEL, UNI, SGL, PD1; din_s is PD0
            if ({cmd_q[0], din_s} == 2'b11) begin
              chan_d      = cmd_q[5:3];
              req_d       = 1'b1;
              busy_d      = 1'b1;
              strb_seen_d = 1'b0;
              state_d     = StStrb;
            end else begin
              err_d   = 1'b1;
              state_d = StIdle;
            end
          end
        end
      end
      StStrb: begin
        if (fall_q) begin
          if (!strb_seen_q) begin
            sstrb_d     = 1'b1;
            strb_seen_d = 1'b1;
          end else begin
            sstrb_d = 1'b0;
            dout0_d = sh0_q[15];
            dout1_d = sh1_q[15];
            sh0_d   = {sh0_q[14:0], 1'b0};
            sh1_d   = {sh1_q[14:0], 1'b0};
            cnt_d   = 5'd1;
            state_d = StData;
          end
        end
      end
      StData: begin
        if (fall_q) begin
          if (cnt_q == 5'd16) begin
            dout0_d    = 1'b0;
            dout1_d    = 1'b0;
            busy_d     = 1'b0;
            frame_done = 1'b1;
            state_d    = StIdle;
          end else begin
            dout0_d = sh0_q[15];
            dout1_d = sh1_q[15];
            sh0_d   = {sh0_q[14:0], 1'b0};
            sh1_d   = {sh1_q[14:0], 1'b0};
            cnt_d   = cnt_q + 5'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign ad_dout0    = dout0_q;
  assign ad_dout1    = dout1_q;
  assign ad_sstrb0   = sstrb_q;
  assign ad_sstrb1   = sstrb_q;
  assign sample_chan = chan_q;
  assign sample_req  = req_q;
  assign cmd_err     = err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_max_adc_responder.sv
// Directed bench for max_adc_responder: reset, accepted/rejected commands, back-to-back frames,
// mid-frame reset and (with MAX_ADC_RESPONDER_RAMP_EN) the internal ramp.
module tb_max_adc_responder;

  localparam int HALF = 8;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        ad_sclk = 1'b0;
  logic        ad_din = 1'b0;
  logic        ad_dout0, ad_sstrb0, ad_dout1, ad_sstrb1;
  logic [2:0]  sample_chan;
  logic        sample_req, cmd_err, busy;
  logic [11:0] sample_data0 = '0;
  logic [11:0] sample_data1 = '0;

  int n_checks = 0;
  int n_fail = 0;
  int req_cnt = 0;
  int err_cnt = 0;
  int strb_cnt = 0;
  logic strb_prev = 1'b0;
  logic [8:0] ramp_cnt [8];

  always #10 CLK = ~CLK;

  max_adc_responder #(
    .DATA_BITS  (12),
    .SYNC_STAGES(2)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .ad_sclk     (ad_sclk),
    .ad_din      (ad_din),
    .ad_dout0    (ad_dout0),
    .ad_sstrb0   (ad_sstrb0),
    .ad_dout1    (ad_dout1),
    .ad_sstrb1   (ad_sstrb1),
    .sample_chan (sample_chan),
    .sample_req  (sample_req),
    .sample_data0(sample_data0),
    .sample_data1(sample_data1),
    .cmd_err     (cmd_err),
    .busy        (busy)
  );

  always @(posedge CLK) begin
    if (sample_req) req_cnt <= req_cnt + 1;
    if (cmd_err) err_cnt <= err_cnt + 1;
    if (ad_sstrb0 && !strb_prev) strb_cnt <= strb_cnt + 1;
    strb_prev <= ad_sstrb0;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] expected(input int lane, input logic [2:0] chan,
                                           input logic [11:0] d);
    logic [11:0] r;
`ifdef MAX_ADC_RESPONDER_RAMP_EN
    r = {chan, ramp_cnt[chan]};
    if (lane != 0) r = ~r;
`else
    r = d;
    if (lane != 0 && chan > 3'd7) r = '0;
`endif
    return {r, 4'h0};
  endfunction

  task automatic wait_half();
    repeat (HALF) @(posedge CLK);
    #1;
  endtask

  task automatic sclk_bit(input logic b);
    ad_din = b;
    wait_half();
    ad_sclk = 1'b1;
    wait_half();
    ad_sclk = 1'b0;
  endtask

  task automatic run_frame(input logic [2:0] chan, input int nlead, input logic fill,
                           input logic [11:0] d0, input logic [11:0] d1);
    logic [7:0]  cmd;
    logic [15:0] got0, got1, e0, e1;
    int          req0, strb0;
    cmd  = {1'b1, chan, 4'b1111};
    e0   = expected(0, chan, d0);
    e1   = expected(1, chan, d1);
    got0 = '0;
    got1 = '0;
    sample_data0 = d0;
    sample_data1 = d1;
    req0  = req_cnt;
    strb0 = strb_cnt;
    for (int i = 0; i < nlead; i++) sclk_bit(1'b0);
    for (int i = 7; i >= 0; i--) sclk_bit(cmd[i]);
    for (int p = 1; p <= 17; p++) begin
      ad_din = fill;
      wait_half();
      if (p == 1) begin
        check("sstrb0 high", ad_sstrb0, 1);
        check("sstrb1 high", ad_sstrb1, 1);
        check("busy in frame", busy, 1);
        check("sample_chan", sample_chan, chan);
        check("sample_req once", req_cnt - req0, 1);
        // Only the captured copy may be transmitted.
        sample_data0 = ~d0;
        sample_data1 = ~d1;
      end else begin
        if (p == 2) check("sstrb0 low", ad_sstrb0, 0);
        got0 = {got0[14:0], ad_dout0};
        got1 = {got1[14:0], ad_dout1};
      end
      ad_sclk = 1'b1;
      wait_half();
      ad_sclk = 1'b0;
    end
    wait_half();
    check("busy after frame", busy, 0);
    check("dout idle after frame", {ad_dout0, ad_dout1}, 0);
    check("sstrb pulses", strb_cnt - strb0, 1);
    check("frame dout0", got0, e0);
    check("frame dout1", got1, e1);
    ramp_cnt[chan] = ramp_cnt[chan] + 9'd1;
  endtask

  initial begin
    logic [7:0] rej;
    int e0, r0, s0;
    for (int i = 0; i < 8; i++) ramp_cnt[i] = '0;
    RST_N = 1'b1;
    #5 RST_N = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    check("rst dout0", ad_dout0, 0);
    check("rst sstrb0", ad_sstrb0, 0);
    check("rst dout1", ad_dout1, 0);
    check("rst sstrb1", ad_sstrb1, 0);
    check("rst sample_chan", sample_chan, 0);
    check("rst sample_req", sample_req, 0);
    check("rst cmd_err", cmd_err, 0);
    check("rst busy", busy, 0);
    RST_N = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    check("idle after release", {ad_dout0, ad_sstrb0, ad_dout1, ad_sstrb1, sample_chan,
                                 sample_req, cmd_err, busy}, 0);

    // Basic frame 0x8F with three leading zeros.
    run_frame(3'd0, 3, 1'b0, 12'hA5C, 12'h123);

    // Rejected byte, then 0xFF accepted.
    rej = 8'hF8;
    e0 = err_cnt;
    r0 = req_cnt;
    s0 = strb_cnt;
    for (int i = 7; i >= 0; i--) sclk_bit(rej[i]);
    for (int i = 0; i < 4; i++) sclk_bit(1'b0);
    check("cmd_err one pulse", err_cnt - e0, 1);
    check("no req on reject", req_cnt - r0, 0);
    check("no sstrb on reject", strb_cnt - s0, 0);
    check("busy on reject", busy, 0);
    run_frame(3'd7, 0, 1'b0, 12'h3C7, 12'hFFF);

    // Back-to-back frames with DIN held high through STRB/DATA.
    r0 = req_cnt;
    run_frame(3'd1, 0, 1'b1, 12'h5A5, 12'h0F0);
    run_frame(3'd2, 0, 1'b1, 12'h001, 12'h800);
    run_frame(3'd3, 0, 1'b1, 12'hFFF, 12'h000);
    check("b2b req count", req_cnt - r0, 3);

    // Reset in the middle of DATA on channel 5.
    rej = 8'hDF;
    sample_data0 = 12'hFFF;
    sample_data1 = 12'hFFF;
    sclk_bit(1'b0);
    for (int i = 7; i >= 0; i--) sclk_bit(rej[i]);
    for (int p = 1; p <= 6; p++) sclk_bit(1'b0);
    ad_din = 1'b0;
    wait_half();
    check("mid-frame dout0", ad_dout0, 1);
    check("mid-frame busy", busy, 1);
    check("mid-frame chan", sample_chan, 5);
    RST_N = 1'b0;
    #1;
    check("abort outputs", {ad_dout0, ad_sstrb0, ad_dout1, ad_sstrb1, sample_chan,
                            sample_req, cmd_err, busy}, 0);
    repeat (3) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    for (int i = 0; i < 8; i++) ramp_cnt[i] = '0;
    wait_half();
    check("post-abort idle", {ad_dout0, ad_sstrb0, busy}, 0);
    run_frame(3'd0, 0, 1'b0, 12'hA5C, 12'h123);

`ifdef MAX_ADC_RESPONDER_RAMP_EN
    for (int k = 0; k < 4; k++) run_frame(3'd2, 1, 1'b0, 12'h000, 12'h000);
    check("ramp chan2 counter", {23'd0, ramp_cnt[2]}, 4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
